// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response channel between the fetch stage and imem.
interface instruction_fetch_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, 2-entry {pc, instruction} queue to IF/ID,
// redirect flush with late-response discard.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       stall_c_i,
    input  logic                       redirect_c_i,
    input  logic [31:0]                redirect_pc_i,
    instruction_fetch_if.master        imem,
    output logic [31:0]                pc_o,
    output logic [31:0]                pc_next_o,
    output logic [31:0]                instruction_o,
    output logic                       valid_o,
    output logic                       fetch_stall_o
);

    typedef enum logic [1:0] {StRun, StWait, StDrop} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    logic        pop;
    logic        push;
    logic        accept;
    logic        slot_free;
    logic        outstanding;
    logic [1:0]  count_after_pop;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc_i & 32'hFFFF_FFFC;
    assign valid_o          = (count_q != 2'd0);
    assign fetch_stall_o    = !valid_o;
    assign pop              = valid_o && !stall_c_i && !redirect_c_i;
    assign push             = (state_q == StWait) && imem.rsp_valid && !redirect_c_i;
    assign outstanding      = (state_q != StRun);
    assign count_after_pop  = count_q - {1'b0, pop};

    // The head leaving this cycle frees its slot, and a returning response frees the
    // outstanding slot; together these sustain one fetch per cycle.
    assign slot_free = (state_q == StRun) || ((state_q == StWait) && imem.rsp_valid);
    assign imem.req_valid = ARESETn && !redirect_c_i && slot_free &&
                            ((count_after_pop + {1'b0, outstanding}) < 2'd2);
    assign imem.req_addr  = fetch_pc_q;
    assign accept         = imem.req_valid && imem.req_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= 32'h0;
                fifo_instr_q[i] <= 32'h0000_0013;
            end
        end else begin
            if (redirect_c_i) begin
                fetch_pc_q <= redirect_aligned;
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                req_pc_q   <= fetch_pc_q;
            end

            case (state_q)
                StRun: begin
                    // A response here is a protocol error and is ignored.
                    if (accept) state_q <= StWait;
                end
                StWait: begin
                    if (imem.rsp_valid) state_q <= accept ? StWait : StRun;
                    else if (redirect_c_i) state_q <= StDrop;
                end
                StDrop: begin
                    if (imem.rsp_valid) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase

            if (redirect_c_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                    fifo_instr_q[wr_ptr_q] <= imem.rsp_data;
                    wr_ptr_q               <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_comb begin
        pc_o          = 32'h0;
        pc_next_o     = 32'd4;
        instruction_o = 32'h0000_0013;
        if (valid_o) begin
            pc_o          = fifo_pc_q[rd_ptr_q];
            pc_next_o     = fifo_pc_q[rd_ptr_q] + 32'd4;
            instruction_o = fifo_instr_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-outstanding memory model whose
// response can be held back to emulate a slow memory.
module tb_instruction_fetch;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic [31:0] instruction_o;
    logic        valid_o;
    logic        fetch_stall_o;

    instruction_fetch_if imem ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .stall_c_i     (stall),
        .redirect_c_i  (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .instruction_o (instruction_o),
        .valid_o       (valid_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 ACLK = ~ACLK;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        pending;
    logic        hold;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Sample the handshake mid-cycle, advance one edge, then update the memory model.
    task automatic clk();
        logic        acc;
        logic        cons;
        logic [31:0] a;
        #1;
        acc  = imem.req_valid && imem.req_ready;
        a    = imem.req_addr;
        cons = imem.rsp_valid;
        @(posedge ACLK);
        #1;
        if (!ARESETn) pending = 1'b0;
        else if (acc) begin
            pending   = 1'b1;
            pend_addr = a;
        end else if (cons) pending = 1'b0;
        imem.rsp_valid = pending && !hold;
        imem.rsp_data  = mem_data(pend_addr);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_valid"}, valid_o, 1'b0);
        chk1({tag, "_fstall"}, fetch_stall_o, 1'b1);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_pcnext"}, pc_next_o, 32'd4);
        chk({tag, "_instr"}, instruction_o, 32'h0000_0013);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk1({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_pcnext"}, pc_next_o, pc + 32'd4);
        chk({tag, "_instr"}, instruction_o, mem_data(pc));
    endtask

    initial begin
        ARESETn        = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = 32'h0;
        pending        = 1'b0;
        hold           = 1'b0;
        pend_addr      = 32'h0;

        #3;
        chk_idle("rst");
        chk1("rst_reqv", imem.req_valid, 1'b0);
        clk();
        ARESETn = 1'b1;
        #1;
        chk1("first_reqv", imem.req_valid, 1'b1);
        chk("first_addr", imem.req_addr, 32'h0);

        // Streaming with 1-cycle memory
        clk();
        chk1("e1_valid", valid_o, 1'b0);
        chk1("e1_reqv", imem.req_valid, 1'b1);
        chk("e1_addr", imem.req_addr, 32'h4);
        clk();
        chk_head("e2", 32'h0);
        chk1("e2_reqv", imem.req_valid, 1'b1);
        chk("e2_addr", imem.req_addr, 32'h8);
        clk();
        chk_head("e3", 32'h4);
        chk("e3_addr", imem.req_addr, 32'hC);
        clk();
        chk_head("e4", 32'h8);

        // Downstream stall for 3 cycles
        stall = 1'b1;
        #1;
        chk1("stall_reqv0", imem.req_valid, 1'b0);
        clk();
        chk_head("stall1", 32'h8);
        chk1("stall1_reqv", imem.req_valid, 1'b0);
        clk();
        chk_head("stall2", 32'h8);
        clk();
        chk_head("stall3", 32'h8);
        chk1("stall3_reqv", imem.req_valid, 1'b0);
        stall = 1'b0;
        #1;
        chk1("unstall_reqv", imem.req_valid, 1'b1);
        chk("unstall_addr", imem.req_addr, 32'h10);
        clk();
        chk_head("unstall1", 32'hC);
        clk();
        chk_head("unstall2", 32'h10);

        // Redirect while a response is held outstanding
        hold           = 1'b1;
        imem.rsp_valid = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk1("redir_reqv", imem.req_valid, 1'b0);
        clk();
        redirect = 1'b0;
        #1;
        chk_idle("drop");
        chk1("drop_reqv", imem.req_valid, 1'b0);
        chk("drop_addr", imem.req_addr, 32'h100);
        hold           = 1'b0;
        imem.rsp_valid = pending;
        #1;
        chk1("drop_rsp_reqv", imem.req_valid, 1'b0);
        clk();
        chk1("drop_done_valid", valid_o, 1'b0);
        chk1("drop_done_reqv", imem.req_valid, 1'b1);
        chk("drop_done_addr", imem.req_addr, 32'h100);
        clk();
        chk1("redir_wait_valid", valid_o, 1'b0);
        clk();
        chk_head("redir_first", 32'h100);

        // Memory not ready for 4 cycles
        imem.req_ready = 1'b0;
        clk();
        chk_head("nrdy1", 32'h104);
        chk("nrdy1_addr", imem.req_addr, 32'h108);
        clk();
        chk_idle("nrdy2");
        chk1("nrdy2_reqv", imem.req_valid, 1'b1);
        chk("nrdy2_addr", imem.req_addr, 32'h108);
        clk();
        clk();
        chk("nrdy4_addr", imem.req_addr, 32'h108);
        imem.req_ready = 1'b1;
        clk();
        chk1("rdy_valid", valid_o, 1'b0);
        chk("rdy_addr", imem.req_addr, 32'h10C);
        clk();
        chk_head("rdy_head", 32'h108);

        // Redirect to the top word, coinciding with a returning response
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        clk();
        redirect = 1'b0;
        #1;
        chk1("wrap_valid", valid_o, 1'b0);
        chk1("wrap_reqv0", imem.req_valid, 1'b1);
        chk("wrap_addr0", imem.req_addr, 32'hFFFF_FFFC);
        clk();
        chk1("wrap_reqv1", imem.req_valid, 1'b1);
        chk("wrap_addr1", imem.req_addr, 32'h0);
        clk();
        chk1("wrap_head_valid", valid_o, 1'b1);
        chk("wrap_head_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_head_pcnext", pc_next_o, 32'h0);
        chk("wrap_head_instr", instruction_o, mem_data(32'hFFFF_FFFC));

        // Fill the queue, then reset asynchronously
        stall = 1'b1;
        clk();
        chk_head("full", 32'hFFFF_FFFC);
        chk1("full_reqv", imem.req_valid, 1'b0);
        ARESETn        = 1'b0;
        pending        = 1'b0;
        imem.rsp_valid = 1'b0;
        #1;
        chk_idle("arst");
        chk1("arst_reqv", imem.req_valid, 1'b0);
        clk();
        ARESETn = 1'b1;
        stall   = 1'b0;
        #1;
        chk1("rerst_reqv", imem.req_valid, 1'b1);
        chk("rerst_addr", imem.req_addr, 32'h0);
        clk();
        clk();
        chk_head("rerst_head", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
